// File: rtl/grid_row_viewer_pkg.sv
// grid_row_viewer_pkg: tile limits, player codes, view modes and the row wrap helper
package grid_row_viewer_pkg;
  localparam int HMAXTILE = 12;
  localparam int VMAXTILE = 16;
  localparam int PLAYERA = 0;
  localparam int PLAYERB = 1;
  typedef enum logic {VIEW_MANUAL = 1'b0, VIEW_AUTO = 1'b1} viewMode_t;
  function automatic logic [3:0] stepRow(input logic [3:0] row, input logic dn, input int vTiles);
    return dn ? ((row == 4'(vTiles - 1)) ? 4'd0 : row + 4'd1)
              : ((row == 4'd0) ? 4'(vTiles - 1) : row - 4'd1);
  endfunction
endpackage

// File: rtl/grid_row_viewer_if.sv
// grid_row_viewer_if: buttons, map/player inputs and LED view outputs of the row viewer
interface grid_row_viewer_if #(parameter int HTILES = 10, parameter int VTILES = 6, parameter int NPLAYERS = 2);
  logic up_pulse;
  logic down_pulse;
  logic mode_toggle;
  logic [HTILES*VTILES-1:0] walk_able;
  logic [4*NPLAYERS-1:0] player_h;
  logic [4*NPLAYERS-1:0] player_v;
  logic [15:0] led;
  logic [3:0] row_idx;
  logic auto_mode;
  modport master (output up_pulse, down_pulse, mode_toggle, walk_able, player_h, player_v,
                  input led, row_idx, auto_mode);
  modport slave (input up_pulse, down_pulse, mode_toggle, walk_able, player_h, player_v,
                 output led, row_idx, auto_mode);
endinterface

// File: rtl/grid_row_viewer_row_overlay.sv
// row_overlay: selects one map row and forces player cells in that row to the blink phase
module row_overlay
  import grid_row_viewer_pkg::*;
#(
  parameter int HTILES = 10,
  parameter int VTILES = 6,
  parameter int NPLAYERS = 2
) (
  input  logic [HTILES*VTILES-1:0] walk_able,
  input  logic [4*NPLAYERS-1:0]    player_h,
  input  logic [4*NPLAYERS-1:0]    player_v,
  input  logic [3:0]               row,
  input  logic                     blink,
  output logic [HTILES-1:0]        rowBits
);
  always_comb begin
    rowBits = '0;
    for (int r = 0; r < VTILES; r++)
      if (row == 4'(r)) rowBits = walk_able[r*HTILES +: HTILES];
    // out-of-range columns never match any c, so such players drop out naturally
    for (int p = 0; p < NPLAYERS; p++)
      for (int c = 0; c < HTILES; c++)
        if (player_v[4*p +: 4] == row && player_h[4*p +: 4] == 4'(c)) rowBits[c] = blink;
  end
endmodule

// File: rtl/grid_row_viewer.sv
// grid_row_viewer: scrollable LED view of one map row with manual/auto row stepping
module grid_row_viewer
  import grid_row_viewer_pkg::*;
#(
  parameter int HTILES = 10,
  parameter int VTILES = 6,
  parameter int NPLAYERS = 2,
  parameter int AUTO_DIV = 4
) (
  input logic clk1hz,
  input logic rst,
  grid_row_viewer_if.slave bus
);
  localparam int CW = AUTO_DIV > 1 ? $clog2(AUTO_DIV) : 1;
  viewMode_t mode, modeNext;
  logic [3:0] row, rowNext;
  logic [CW-1:0] autoCnt, autoCntNext;
  logic blink, manStep, autoStep, stayAuto;
  logic [HTILES-1:0] rowBits;
  logic [HMAXTILE-1:0] ledLow;
  always_ff @(posedge clk1hz) begin
    if (rst) begin
      mode <= VIEW_MANUAL;
      row <= '0;
      autoCnt <= '0;
      blink <= 1'b0;
    end else begin
      mode <= modeNext;
      row <= rowNext;
      autoCnt <= autoCntNext;
      blink <= ~blink;
    end
  end
  // simultaneous up+down cancel; only a staying-AUTO cycle without a manual step counts
  always_comb begin
    modeNext = bus.mode_toggle ? ((mode == VIEW_MANUAL) ? VIEW_AUTO : VIEW_MANUAL) : mode;
    manStep = bus.up_pulse ^ bus.down_pulse;
    stayAuto = mode == VIEW_AUTO && modeNext == VIEW_AUTO && !manStep;
    autoStep = stayAuto && autoCnt == CW'(AUTO_DIV - 1);
    rowNext = manStep ? stepRow(row, bus.down_pulse, VTILES) : autoStep ? stepRow(row, 1'b1, VTILES) : row;
    autoCntNext = (stayAuto && !autoStep) ? autoCnt + CW'(1) : '0;
  end
  row_overlay #(.HTILES(HTILES), .VTILES(VTILES), .NPLAYERS(NPLAYERS)) u_overlay (
    .walk_able(bus.walk_able),
    .player_h(bus.player_h),
    .player_v(bus.player_v),
    .row(row),
    .blink(blink),
    .rowBits(rowBits)
  );
  always_comb begin
    ledLow = '0;
    ledLow[HTILES-1:0] = rowBits;
  end
  assign bus.led = {row, ledLow};
  assign bus.row_idx = row;
  assign bus.auto_mode = mode == VIEW_AUTO;
endmodule
